// File: rtl/axi4lite_dist_n.sv
// AXI4-Lite 1:N distributor. One slave inport is routed to one of NUM_PORTS
// master outports chosen by addr[ADDR_SEL_LSB +: ADDR_SEL_BITS]; selects at or
// above NUM_PORTS are answered locally with DECERR.
// Ports:
//   clk_i, rst_i (async, active-low)
//   inport_*   : AW/W/B/AR/R slave channels from the CPU bus
//   outport_*  : per-port handshakes (NUM_PORTS wide); addr/data/strb are
//                broadcast, port n occupies slice [W*n +: W]
// Write and read paths are independent FSMs, one transaction outstanding each.
module axi4lite_dist_n #(
  parameter int unsigned NUM_PORTS     = 8,
  parameter int unsigned ADDR_SEL_LSB  = 8,
  parameter int unsigned ADDR_SEL_BITS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // inport
  input  logic                      inport_awvalid_i,
  output logic                      inport_awready_o,
  input  logic [31:0]               inport_awaddr_i,
  input  logic                      inport_wvalid_i,
  output logic                      inport_wready_o,
  input  logic [31:0]               inport_wdata_i,
  input  logic [3:0]                inport_wstrb_i,
  output logic                      inport_bvalid_o,
  input  logic                      inport_bready_i,
  output logic [1:0]                inport_bresp_o,
  input  logic                      inport_arvalid_i,
  output logic                      inport_arready_o,
  input  logic [31:0]               inport_araddr_i,
  output logic                      inport_rvalid_o,
  input  logic                      inport_rready_i,
  output logic [31:0]               inport_rdata_o,
  output logic [1:0]                inport_rresp_o,
  // outports
  output logic [NUM_PORTS-1:0]      outport_awvalid_o,
  input  logic [NUM_PORTS-1:0]      outport_awready_i,
  output logic [32*NUM_PORTS-1:0]   outport_awaddr_o,
  output logic [NUM_PORTS-1:0]      outport_wvalid_o,
  input  logic [NUM_PORTS-1:0]      outport_wready_i,
  output logic [32*NUM_PORTS-1:0]   outport_wdata_o,
  output logic [4*NUM_PORTS-1:0]    outport_wstrb_o,
  input  logic [NUM_PORTS-1:0]      outport_bvalid_i,
  output logic [NUM_PORTS-1:0]      outport_bready_o,
  input  logic [2*NUM_PORTS-1:0]    outport_bresp_i,
  output logic [NUM_PORTS-1:0]      outport_arvalid_o,
  input  logic [NUM_PORTS-1:0]      outport_arready_i,
  output logic [32*NUM_PORTS-1:0]   outport_araddr_o,
  input  logic [NUM_PORTS-1:0]      outport_rvalid_i,
  output logic [NUM_PORTS-1:0]      outport_rready_o,
  input  logic [32*NUM_PORTS-1:0]   outport_rdata_i,
  input  logic [2*NUM_PORTS-1:0]    outport_rresp_i
);

  localparam int unsigned SW = ADDR_SEL_BITS;
  localparam logic [SW:0] NP_CMP = (SW+1)'(NUM_PORTS);
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [1:0] W_ERR  = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;
  localparam logic [1:0] R_ERR  = 2'd3;

  logic [1:0]           wstate_q, wstate_d, rstate_q, rstate_d;
  logic                 active_q, active_d;
  logic [31:0]          awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [SW-1:0]        wsel_q, wsel_d, rsel_q, rsel_d;
  logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [SW-1:0]        aw_sel, ar_sel;
  logic [NUM_PORTS-1:0] wsel_oh, rsel_oh;
  logic                 sel_awready, sel_wready, sel_bvalid, sel_arready, sel_rvalid;
  logic [1:0]           sel_bresp, sel_rresp;
  logic [31:0]          sel_rdata;
  logic                 aw_hs, w_hs;

  function automatic logic is_mapped(input logic [SW-1:0] s);
    return {1'b0, s} < NP_CMP;
  endfunction

  assign aw_sel = inport_awaddr_i[ADDR_SEL_LSB +: ADDR_SEL_BITS];
  assign ar_sel = inport_araddr_i[ADDR_SEL_LSB +: ADDR_SEL_BITS];

  // Captured request fields are broadcast; only the selected valid qualifies them.
  assign outport_awaddr_o = {NUM_PORTS{awaddr_q}};
  assign outport_wdata_o  = {NUM_PORTS{wdata_q}};
  assign outport_wstrb_o  = {NUM_PORTS{wstrb_q}};
  assign outport_araddr_o = {NUM_PORTS{araddr_q}};

  // Select decode and return-path muxing for the captured selects.
  always_comb begin
    wsel_oh     = '0;
    rsel_oh     = '0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bresp   = 2'b00;
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rresp   = 2'b00;
    sel_rdata   = 32'h0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      wsel_oh[p] = (wsel_q == SW'(p));
      rsel_oh[p] = (rsel_q == SW'(p));
      if (wsel_oh[p]) begin
        sel_awready = outport_awready_i[p];
        sel_wready  = outport_wready_i[p];
        sel_bvalid  = outport_bvalid_i[p];
        sel_bresp   = outport_bresp_i[2*p +: 2];
      end
      if (rsel_oh[p]) begin
        sel_arready = outport_arready_i[p];
        sel_rvalid  = outport_rvalid_i[p];
        sel_rresp   = outport_rresp_i[2*p +: 2];
        sel_rdata   = outport_rdata_i[32*p +: 32];
      end
    end
  end

  // Write path FSM; AW and W are only accepted together.
  always_comb begin
    wstate_d          = wstate_q;
    awaddr_d          = awaddr_q;
    wdata_d           = wdata_q;
    wstrb_d           = wstrb_q;
    wsel_d            = wsel_q;
    aw_done_d         = aw_done_q;
    w_done_d          = w_done_q;
    aw_hs             = 1'b0;
    w_hs              = 1'b0;
    inport_awready_o  = 1'b0;
    inport_wready_o   = 1'b0;
    inport_bvalid_o   = 1'b0;
    inport_bresp_o    = 2'b00;
    outport_awvalid_o = '0;
    outport_wvalid_o  = '0;
    outport_bready_o  = '0;
    case (wstate_q)
      W_IDLE: begin
        // active_q keeps readies low while reset is asserted
        if (active_q && inport_awvalid_i && inport_wvalid_i) begin
          inport_awready_o = 1'b1;
          inport_wready_o  = 1'b1;
          awaddr_d         = inport_awaddr_i;
          wdata_d          = inport_wdata_i;
          wstrb_d          = inport_wstrb_i;
          wsel_d           = aw_sel;
          aw_done_d        = 1'b0;
          w_done_d         = 1'b0;
          wstate_d         = is_mapped(aw_sel) ? W_REQ : W_ERR;
        end
      end
      W_REQ: begin
        outport_awvalid_o = aw_done_q ? '0 : wsel_oh;
        outport_wvalid_o  = w_done_q  ? '0 : wsel_oh;
        aw_hs             = !aw_done_q && sel_awready;
        w_hs              = !w_done_q && sel_wready;
        aw_done_d         = aw_done_q || aw_hs;
        w_done_d          = w_done_q || w_hs;
        if (aw_done_d && w_done_d) wstate_d = W_RESP;
      end
      W_RESP: begin
        inport_bvalid_o  = sel_bvalid;
        inport_bresp_o   = sel_bresp;
        outport_bready_o = inport_bready_i ? wsel_oh : '0;
        if (sel_bvalid && inport_bready_i) wstate_d = W_IDLE;
      end
      W_ERR: begin
        inport_bvalid_o = 1'b1;
        inport_bresp_o  = RESP_DECERR;
        if (inport_bready_i) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read path FSM.
  always_comb begin
    rstate_d          = rstate_q;
    araddr_d          = araddr_q;
    rsel_d            = rsel_q;
    inport_arready_o  = 1'b0;
    inport_rvalid_o   = 1'b0;
    inport_rdata_o    = 32'h0;
    inport_rresp_o    = 2'b00;
    outport_arvalid_o = '0;
    outport_rready_o  = '0;
    case (rstate_q)
      R_IDLE: begin
        inport_arready_o = active_q;
        if (active_q && inport_arvalid_i) begin
          araddr_d = inport_araddr_i;
          rsel_d   = ar_sel;
          rstate_d = is_mapped(ar_sel) ? R_REQ : R_ERR;
        end
      end
      R_REQ: begin
        outport_arvalid_o = rsel_oh;
        if (sel_arready) rstate_d = R_RESP;
      end
      R_RESP: begin
        inport_rvalid_o  = sel_rvalid;
        inport_rdata_o   = sel_rdata;
        inport_rresp_o   = sel_rresp;
        outport_rready_o = inport_rready_i ? rsel_oh : '0;
        if (sel_rvalid && inport_rready_i) rstate_d = R_IDLE;
      end
      R_ERR: begin
        inport_rvalid_o = 1'b1;
        inport_rresp_o  = RESP_DECERR;
        if (inport_rready_i) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Goes high on the first clock after reset release.
  assign active_d = 1'b1;

  // State and capture registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      active_q  <= 1'b0;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      araddr_q  <= 32'h0;
      wsel_q    <= '0;
      rsel_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      active_q  <= active_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_dist_n.sv
// Bench for axi4lite_dist_n: directed scenarios plus randomized write/readback
// against a sparse memory reference model and per-port slave responders.
module tb_axi4lite_dist_n;

  localparam int NP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  logic [NP-1:0] o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic [NP-1:0] o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
  logic [32*NP-1:0] o_awaddr, o_wdata, o_araddr, o_rdata;
  logic [4*NP-1:0]  o_wstrb;
  logic [2*NP-1:0]  o_bresp, o_rresp;

  axi4lite_dist_n #(.NUM_PORTS(NP), .ADDR_SEL_LSB(8), .ADDR_SEL_BITS(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .inport_awvalid_i(awvalid), .inport_awready_o(awready), .inport_awaddr_i(awaddr),
    .inport_wvalid_i(wvalid), .inport_wready_o(wready), .inport_wdata_i(wdata),
    .inport_wstrb_i(wstrb), .inport_bvalid_o(bvalid), .inport_bready_i(bready),
    .inport_bresp_o(bresp), .inport_arvalid_i(arvalid), .inport_arready_o(arready),
    .inport_araddr_i(araddr), .inport_rvalid_o(rvalid), .inport_rready_i(rready),
    .inport_rdata_o(rdata), .inport_rresp_o(rresp),
    .outport_awvalid_o(o_awvalid), .outport_awready_i(o_awready), .outport_awaddr_o(o_awaddr),
    .outport_wvalid_o(o_wvalid), .outport_wready_i(o_wready), .outport_wdata_o(o_wdata),
    .outport_wstrb_o(o_wstrb), .outport_bvalid_i(o_bvalid), .outport_bready_o(o_bready),
    .outport_bresp_i(o_bresp), .outport_arvalid_o(o_arvalid), .outport_arready_i(o_arready),
    .outport_araddr_o(o_araddr), .outport_rvalid_i(o_rvalid), .outport_rready_o(o_rready),
    .outport_rdata_i(o_rdata), .outport_rresp_i(o_rresp)
  );

  // Slave timing knobs shared by all ports.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;

  int          wcnt  [NP];
  logic [31:0] l_awa [NP];
  logic [31:0] l_wd  [NP];

  // Per-port slave: word memory, programmable ready/response delays.
  // Port 6 answers SLVERR on both directions.
  for (genvar g = 0; g < NP; g++) begin : g_slv
    logic [31:0] mem [64];
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, wr_cnt = 0;
    logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [31:0] awa = '0, wd = '0, rd_q = '0;
    logic [3:0]  ws = '0;
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    assign o_awready[g] = o_awvalid[g] && (aw_cnt >= aw_dly);
    assign o_wready[g]  = o_wvalid[g] && (w_cnt >= w_dly);
    assign o_arready[g] = o_arvalid[g] && (ar_cnt >= ar_dly);
    assign o_bvalid[g]  = b_pend && (b_cnt >= b_dly);
    assign o_rvalid[g]  = r_pend && (r_cnt > r_dly);
    assign o_bresp[2*g +: 2] = (g == 6) ? 2'b10 : 2'b00;
    assign o_rresp[2*g +: 2] = (g == 6) ? 2'b10 : 2'b00;
    assign o_rdata[32*g +: 32] = o_rvalid[g] ? rd_q : (32'hBAD0_0000 | 32'(g));
    assign wcnt[g]  = wr_cnt;
    assign l_awa[g] = awa;
    assign l_wd[g]  = wd;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      end else begin
        aw_cnt <= (o_awvalid[g] && !o_awready[g]) ? aw_cnt + 1 : 0;
        w_cnt  <= (o_wvalid[g] && !o_wready[g]) ? w_cnt + 1 : 0;
        ar_cnt <= (o_arvalid[g] && !o_arready[g]) ? ar_cnt + 1 : 0;
        if (o_awvalid[g] && o_awready[g]) begin aw_got <= 1'b1; awa <= o_awaddr[32*g +: 32]; end
        if (o_wvalid[g] && o_wready[g]) begin
          w_got <= 1'b1; wd <= o_wdata[32*g +: 32]; ws <= o_wstrb[4*g +: 4];
        end
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++) if (ws[b]) mem[awa[7:2]][8*b +: 8] <= wd[8*b +: 8];
          aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0; wr_cnt <= wr_cnt + 1;
        end else if (b_pend) begin
          if (o_bvalid[g] && o_bready[g]) b_pend <= 1'b0; else b_cnt <= b_cnt + 1;
        end
        if (o_arvalid[g] && o_arready[g]) begin
          r_pend <= 1'b1; r_cnt <= 0; rd_q <= mem[o_araddr[32*g+2 +: 6]];
        end else if (r_pend) begin
          if (o_rvalid[g] && o_rready[g]) r_pend <= 1'b0; else r_cnt <= r_cnt + 1;
        end
      end
    end
  end

  // Outport activity monitor: cycles with any request valid, and one-hot violations.
  int vcnt [NP] = '{default: 0};
  int onehot_err = 0;
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++)
      if (o_awvalid[p] || o_wvalid[p] || o_arvalid[p]) vcnt[p] <= vcnt[p] + 1;
    if ($countones(o_awvalid) > 1 || $countones(o_wvalid) > 1 || $countones(o_arvalid) > 1)
      onehot_err <= onehot_err + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: sparse memory keyed by {select, word}.
  logic [31:0] ref_mem [int];

  function automatic bit mapped(input logic [31:0] a);
    return int'(a[11:8]) < NP;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (!mapped(a)) return 2'b11;
    return (a[11:8] == 4'd6) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (!mapped(a)) return 32'h0;
    return ref_mem.exists(int'(a[11:2])) ? ref_mem[int'(a[11:2])] : 32'h0;
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    if (!mapped(a)) return;
    v = model_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a[11:2])] = v;
  endfunction

  function automatic int other_sum(input int excl);
    int s = 0;
    for (int p = 0; p < NP; p++) if (p != excl) s += vcnt[p];
    return s;
  endfunction

  function automatic logic [NP-1:0] exp_oh(input logic [31:0] a);
    logic [NP-1:0] v = '0;
    if (mapped(a)) v[a[10:8]] = 1'b1;
    return v;
  endfunction

  // Inport write; hold = cycles bready stays low after bvalid. lat counts cycles
  // from acceptance to bvalid (1 = the cycle right after acceptance).
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int hold, output logic [1:0] resp, output int lat, output longint t_acc);
    bit hs = 0; int n = 0; logic [31:0] dummy;
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s;
    while (!hs && n < 50) begin #1 hs = awready && wready; @(negedge clk); n++; end
    check("wr_accept", 64'(hs), 64'd1);
    awvalid = 1'b0; wvalid = 1'b0; t_acc = $time;
    #1;
    check("wr_awvalid_fwd", 64'(o_awvalid), 64'(exp_oh(a)));
    check("wr_wvalid_fwd", 64'(o_wvalid), 64'(exp_oh(a)));
    if (mapped(a)) begin
      dummy = o_awaddr[32*int'(a[10:8]) +: 32];
      check("wr_awaddr_bcast", 64'(dummy), 64'(a));
    end
    check("wr_b_early", 64'(bvalid), 64'(!mapped(a)));
    lat = 1; n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); #1; lat++; n++; end
    check("wr_b_seen", 64'(bvalid), 64'd1);
    repeat (hold) begin @(negedge clk); #1; check("wr_b_hold", 64'(bvalid), 64'd1); end
    resp = bresp;
    bready = 1'b1;
    @(negedge clk); bready = 1'b0; #1;
    check("wr_b_drop", 64'(bvalid), 64'd0);
  endtask

  task automatic rd(input logic [31:0] a, input int hold, output logic [31:0] data,
                    output logic [1:0] resp, output int lat, output longint t_acc);
    bit hs = 0; int n = 0; logic [31:0] dummy;
    @(negedge clk);
    arvalid = 1'b1; araddr = a;
    while (!hs && n < 50) begin #1 hs = arready; @(negedge clk); n++; end
    check("rd_accept", 64'(hs), 64'd1);
    arvalid = 1'b0; t_acc = $time;
    #1;
    check("rd_arvalid_fwd", 64'(o_arvalid), 64'(exp_oh(a)));
    if (mapped(a)) begin
      dummy = o_araddr[32*int'(a[10:8]) +: 32];
      check("rd_araddr_bcast", 64'(dummy), 64'(a));
    end
    check("rd_r_early", 64'(rvalid), 64'(!mapped(a)));
    lat = 1; n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); #1; lat++; n++; end
    check("rd_r_seen", 64'(rvalid), 64'd1);
    data = rdata; resp = rresp;
    repeat (hold) begin
      @(negedge clk); #1;
      check("rd_r_hold", 64'(rvalid), 64'd1);
      check("rd_data_stable", 64'(rdata), 64'(data));
    end
    rready = 1'b1;
    @(negedge clk); rready = 1'b0; #1;
    check("rd_r_drop", 64'(rvalid), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [1:0] rs, rs2; logic [31:0] rdv; int la, la2, os, wc0;
    longint ta, ta2;

    // Reset state, including with inport valids presented.
    #12;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; #1;
    check("rst_ready", 64'({awready, wready, arready}), 64'd0);
    check("rst_valid", 64'({bvalid, rvalid}), 64'd0);
    check("rst_resp", 64'({bresp, rresp}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_outvalid", 64'({o_awvalid, o_wvalid, o_arvalid}), 64'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Write port 2, zero-wait slave.
    os = other_sum(2); wc0 = wcnt[2];
    wr(32'h0000_0204, 32'hDEADBEEF, 4'hF, 0, rs, la, ta); model_wr(32'h204, 32'hDEADBEEF, 4'hF);
    check("p2_bresp", 64'(rs), 64'd0);
    check("p2_blat", 64'(la), 64'd3);
    check("p2_wcnt", 64'(wcnt[2]), 64'(wc0 + 1));
    check("p2_awaddr", 64'(l_awa[2]), 64'h204);
    check("p2_wdata", 64'(l_wd[2]), 64'hDEADBEEF);
    check("p2_others_quiet", 64'(other_sum(2)), 64'(os));

    // Read port 5 with a slow slave and held rready; zero-wait read of port 2.
    wr(32'h0000_0500, 32'h12345678, 4'hF, 0, rs, la, ta); model_wr(32'h500, 32'h12345678, 4'hF);
    r_dly = 4;
    rd(32'h0000_0500, 3, rdv, rs, la, ta);
    check("p5_rdata", 64'(rdv), 64'(model_rd(32'h500)));
    check("p5_rresp", 64'(rs), 64'd0);
    r_dly = 0;
    rd(32'h0000_0204, 0, rdv, rs, la, ta);
    check("p2_rdata", 64'(rdv), 64'hDEADBEEF);
    check("p2_rlat", 64'(la), 64'd3);

    // Unmapped select 12: local DECERR, no outport touched.
    os = other_sum(-1);
    wr(32'h0000_0C00, 32'h1111_2222, 4'hF, 1, rs, la, ta);
    check("dec_bresp", 64'(rs), 64'd3);
    check("dec_blat", 64'(la), 64'd1);
    rd(32'h0000_0C00, 1, rdv, rs, la, ta);
    check("dec_rresp", 64'(rs), 64'd3);
    check("dec_rdata", 64'(rdv), 64'd0);
    check("dec_rlat", 64'(la), 64'd1);
    check("dec_quiet", 64'(other_sum(-1)), 64'(os));

    // Port 3: wready before awready, then awready before wready.
    wc0 = wcnt[3];
    aw_dly = 2; w_dly = 0;
    wr(32'h0000_0308, 32'hA5A5_0001, 4'hF, 0, rs, la, ta); model_wr(32'h308, 32'hA5A5_0001, 4'hF);
    check("p3a_bresp", 64'(rs), 64'd0);
    check("p3a_wcnt", 64'(wcnt[3]), 64'(wc0 + 1));
    aw_dly = 0; w_dly = 2;
    wr(32'h0000_030C, 32'hA5A5_0002, 4'hF, 0, rs, la, ta); model_wr(32'h30C, 32'hA5A5_0002, 4'hF);
    check("p3b_bresp", 64'(rs), 64'd0);
    check("p3b_wcnt", 64'(wcnt[3]), 64'(wc0 + 2));
    w_dly = 0;
    rd(32'h0000_0308, 0, rdv, rs, la, ta);
    check("p3a_rdata", 64'(rdv), 64'(model_rd(32'h308)));
    rd(32'h0000_030C, 0, rdv, rs, la, ta);
    check("p3b_rdata", 64'(rdv), 64'(model_rd(32'h30C)));

    // Concurrent write and read to port 1.
    wr(32'h0000_0104, 32'hCAFE_F00D, 4'hF, 0, rs, la, ta); model_wr(32'h104, 32'hCAFEF00D, 4'hF);
    fork
      wr(32'h0000_0110, 32'h0BAD_C0DE, 4'hF, 0, rs, la, ta);
      rd(32'h0000_0104, 2, rdv, rs2, la2, ta2);
    join
    model_wr(32'h110, 32'h0BADC0DE, 4'hF);
    check("cc_same_cycle", 64'(ta), 64'(ta2));
    check("cc_bresp", 64'(rs), 64'd0);
    check("cc_rresp", 64'(rs2), 64'd0);
    check("cc_rdata", 64'(rdv), 64'hCAFEF00D);
    rd(32'h0000_0110, 0, rdv, rs, la, ta);
    check("cc_wdata", 64'(rdv), 64'h0BADC0DE);

    // Port 6 error responses pass through.
    wr(32'h0000_0600, 32'h0000_0066, 4'h1, 0, rs, la, ta); model_wr(32'h600, 32'h66, 4'h1);
    check("p6_bresp", 64'(rs), 64'd2);
    rd(32'h0000_0600, 0, rdv, rs, la, ta);
    check("p6_rresp", 64'(rs), 64'd2);

    // Reset while in W_REQ to port 4.
    aw_dly = 10; w_dly = 10; wc0 = wcnt[4];
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h404; wdata = 32'h4444_4444; wstrb = 4'hF;
    #1 check("rq_accept", 64'({awready, wready}), 64'd3);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; #1;
    check("rq_awvalid4", 64'(o_awvalid[4]), 64'd1);
    @(negedge clk); #1;
    check("rq_awvalid4_hold", 64'(o_awvalid[4]), 64'd1);
    #1 rst_n = 1'b0; #1;
    check("rq_awvalid_drop", 64'({o_awvalid, o_wvalid}), 64'd0);
    check("rq_bvalid_rst", 64'(bvalid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; aw_dly = 0; w_dly = 0;
    #1 check("rq_idle_after", 64'({o_awvalid, o_wvalid, bvalid}), 64'd0);
    check("rq_no_commit", 64'(wcnt[4]), 64'(wc0));
    wr(32'h0000_0404, 32'h0404_0404, 4'hF, 0, rs, la, ta); model_wr(32'h404, 32'h04040404, 4'hF);
    check("rq_bresp", 64'(rs), 64'd0);
    check("rq_wcnt", 64'(wcnt[4]), 64'(wc0 + 1));
    check("rq_wdata", 64'(l_wd[4]), 64'h0404_0404);

    // Randomized write/readback against the reference model.
    for (int it = 0; it < 30; it++) begin
      logic [31:0] a, d; logic [3:0] s; int sel;
      sel = int'($urandom_range(15, 0));
      a = {20'h0, 4'(sel), 6'($urandom_range(63, 0)), 2'b00};
      d = $urandom; s = 4'($urandom_range(15, 0));
      aw_dly = int'($urandom_range(3, 0)); w_dly = int'($urandom_range(3, 0));
      ar_dly = int'($urandom_range(3, 0)); b_dly = int'($urandom_range(3, 0));
      r_dly = int'($urandom_range(3, 0));
      wc0 = (sel < NP) ? wcnt[sel] : 0;
      os = other_sum(sel);
      wr(a, d, s, int'($urandom_range(2, 0)), rs, la, ta);
      model_wr(a, d, s);
      check("rnd_bresp", 64'(rs), 64'(exp_resp(a)));
      if (sel < NP) check("rnd_wcnt", 64'(wcnt[sel]), 64'(wc0 + 1));
      rd(a, int'($urandom_range(2, 0)), rdv, rs, la, ta);
      check("rnd_rresp", 64'(rs), 64'(exp_resp(a)));
      check("rnd_rdata", 64'(rdv), 64'(model_rd(a)));
      check("rnd_others_quiet", 64'(other_sum(sel)), 64'(os));
    end

    check("onehot_outvalid", 64'(onehot_err), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
